equalizer_8band: RTL and testbench
==================================

Name: equalizer_8band

Overview:
- 8-band audio graphic equalizer core: one 16-bit signed sample stream in, eight independently gated and scaled band outputs.
- Each band is a fixed-coefficient FIR band-pass filter. All bands share one input delay line.
- Each band result is multiplied by a 3-bit per-band gain and driven on its own 32-bit output.
- Sits between the sample source (one sample per clock) and the downstream band mixer/DAC path.

Parameters:
- NTAPS, 16, taps per band FIR (shared delay-line length).
- DW, 16, input sample width (signed two's complement).
- CW, 16, coefficient width (signed Q1.15).
- OW, 32, band output width (signed).
- GW, 3, gain width (unsigned).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-high (asserted = 1, despite the name suffix).
- x_in  in  DW  signed input sample, one new sample accepted every clock.
- ena_1..ena_8  in  1 each  band enable; 1 = band output active, 0 = band output forced to 0.
- amp_coef_1..amp_coef_8  in  GW each  unsigned per-band gain, 0..7.
- sig_out_1..sig_out_8  out  OW each  signed band output, registered.

Behaviour:
- Reset (rst_n=1 at a rising edge):
  - all delay-line taps clear to 0;
  - all sig_out_k clear to 0;
  - reset dominates ena and x_in.
- Delay line:
  - every non-reset edge: tap[0] <= x_in, tap[i] <= tap[i-1];
  - runs regardless of any ena_k.
- Band k accumulator (combinational):
  - acc_k = sum over i=0..NTAPS-1 of tap[i] * COEF[k][i];
  - full precision, 40-bit signed, no truncation.
- Gain:
  - g_k = acc_k * amp_coef_k, with amp_coef_k zero-extended (unsigned);
  - g_k is then saturated to the signed OW range: max 0x7FFFFFFF, min 0x80000000.
- Output register:
  - every non-reset edge: sig_out_k <= ena_k ? sat(g_k) : 0.
- Latency:
  - a sample present on x_in before edge t enters tap[0] at t;
  - its tap[0] contribution appears on sig_out_k after edge t+1 (2-edge latency);
  - it moves to tap[i] contribution i edges later.
- ena_k deasserted mid-stream: sig_out_k = 0 from the next edge. Filter history is preserved.
- ena_k reasserted: output immediately reflects the current delay-line contents. No flush or settling period.
- amp_coef_k = 0: sig_out_k = 0. Gain changes take effect at the next edge with no smoothing.
- Bands are fully independent; no interaction between enables or gains.
- Reset mid-stream: history is lost; outputs stay 0 until samples refill the line.

Decomposition:
- Shared package eq_pkg holds:
  - NTAPS, DW, CW, OW, GW, NBANDS=8;
  - COEF[8][NTAPS] signed Q1.15 band-pass tables, designed offline; symmetric, linear-phase; centre frequencies octave-spaced, band 1 lowest;
  - the saturation width constant.
- One sub-module, eq_band_fir:
  - inputs: the shared tap vector, a band index parameter, ena, amp_coef;
  - contains the MAC, gain, saturation and output register;
  - the top instantiates the delay line plus 8 eq_band_fir instances.

Test Plan:
- Reset: drive x_in=0x7FFF, all ena=1, amp=7, rst_n=1 for 3 edges -> all sig_out=0, all taps 0. Release and hold x_in=0 -> outputs stay 0.
- Impulse: x_in=1000 for one cycle then 0, all ena=1, amp=1 -> sig_out_k at edge t+1+n equals 1000*COEF[k][n] for n=0..15, then 0.
- Gain: repeat impulse with amp_coef_3=5, amp_coef_6=0 -> sig_out_3 = 5× its amp=1 values; sig_out_6 = 0 throughout; other bands unchanged.
- Enable gating: steady random stream; at cycle 2000 drop ena_3 and ena_7 -> sig_out_3/7 = 0 from next edge, other bands bit-identical to golden model. Re-raise ena_3 -> matches golden immediately.
- Saturation: x_in=0x7FFF constant, amp=7 on all bands -> any band whose sum·7 exceeds range reads exactly 0x7FFFFFFF. Same test with x_in=0x8000 -> 0x80000000.
- Wrap stream: 8000-sample file played cyclically -> all outputs match a bit-exact reference model over 2 full passes with no discontinuity at the wrap.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared constants, band-pass coefficient tables and output saturation helper
// for the 8-band graphic equalizer.
package eq_pkg;

   localparam int NTAPS  = 16;
   localparam int DW     = 16;
   localparam int CW     = 16;
   localparam int OW     = 32;
   localparam int GW     = 3;
   localparam int NBANDS = 8;

   // Full-precision MAC width and the wider gained value that gets saturated.
   localparam int ACC_W = 40;
   localparam int SAT_W = ACC_W + GW + 1;

   typedef logic signed [CW-1:0] coef_t;

   // Symmetric linear-phase band-pass taps, band 1 lowest, octave-spaced centres.
   localparam coef_t COEF [NBANDS][NTAPS] = '{
      '{16'sd100, 16'sd300, 16'sd700, 16'sd1200, 16'sd1800, 16'sd2400, 16'sd2900, 16'sd3200, 16'sd3200, 16'sd2900, 16'sd2400, 16'sd1800, 16'sd1200, 16'sd700, 16'sd300, 16'sd100},
      '{-16'sd300, -16'sd500, -16'sd400, 16'sd200, 16'sd1100, 16'sd2000, 16'sd2600, 16'sd2800, 16'sd2800, 16'sd2600, 16'sd2000, 16'sd1100, 16'sd200, -16'sd400, -16'sd500, -16'sd300},
      '{16'sd200, 16'sd400, 16'sd0, -16'sd900, -16'sd1400, -16'sd300, 16'sd1800, 16'sd3300, 16'sd3300, 16'sd1800, -16'sd300, -16'sd1400, -16'sd900, 16'sd0, 16'sd400, 16'sd200},
      '{-16'sd100, 16'sd500, 16'sd600, -16'sd700, -16'sd1800, 16'sd300, 16'sd2900, 16'sd1500, 16'sd1500, 16'sd2900, 16'sd300, -16'sd1800, -16'sd700, 16'sd600, 16'sd500, -16'sd100},
      '{16'sd300, -16'sd200, -16'sd900, 16'sd600, 16'sd1700, -16'sd1600, -16'sd1900, 16'sd3000, 16'sd3000, -16'sd1900, -16'sd1600, 16'sd1700, 16'sd600, -16'sd900, -16'sd200, 16'sd300},
      '{-16'sd200, -16'sd600, 16'sd900, 16'sd500, -16'sd2000, 16'sd1100, 16'sd2200, -16'sd2900, -16'sd2900, 16'sd2200, 16'sd1100, -16'sd2000, 16'sd500, 16'sd900, -16'sd600, -16'sd200},
      '{16'sd100, 16'sd700, -16'sd1200, 16'sd1300, -16'sd800, -16'sd600, 16'sd2100, -16'sd3100, -16'sd3100, 16'sd2100, -16'sd600, -16'sd800, 16'sd1300, -16'sd1200, 16'sd700, 16'sd100},
      '{-16'sd300, 16'sd600, -16'sd900, 16'sd1200, -16'sd1500, 16'sd1800, -16'sd2100, 16'sd2400, 16'sd2400, -16'sd2100, 16'sd1800, -16'sd1500, 16'sd1200, -16'sd900, 16'sd600, -16'sd300}
   };

   // Clamp to the signed OW range: in range iff all bits from OW-1 upward agree.
   function automatic logic [OW-1:0] sat_ow(input logic signed [SAT_W-1:0] g);
      logic [OW-1:0] res;
      if ((&g[SAT_W-1:OW-1]) || !(|g[SAT_W-1:OW-1])) begin
         res = g[OW-1:0];
      end else if (g[SAT_W-1]) begin
         res = {1'b1, {(OW-1){1'b0}}};
      end else begin
         res = {1'b0, {(OW-1){1'b1}}};
      end
      return res;
   endfunction

endpackage

// File: rtl/eq_band_fir.sv
// One equalizer band: MAC over the shared delay line, unsigned gain,
// saturation to OW bits and the gated output register.
module eq_band_fir
   import eq_pkg::*;
#(
   parameter int BAND = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NTAPS-1:0][DW-1:0]     taps,
   input  logic                         ena,
   input  logic [GW-1:0]                amp_coef,
   output logic signed [OW-1:0]         sig_out
);

   logic signed [DW+CW-1:0] prod_s;
   logic signed [ACC_W-1:0] acc_s;
   logic signed [SAT_W-1:0] gain_s;

   // Full-precision sum of tap products against this band's coefficients.
   always_comb begin
      prod_s = '0;
      acc_s  = '0;
      for (int i = 0; i < NTAPS; i++) begin
         prod_s = $signed(taps[i]) * COEF[BAND][i];
         acc_s  = acc_s + ACC_W'(prod_s);
      end
   end

   // Gain is unsigned, so it is zero-extended before the signed multiply.
   assign gain_s = SAT_W'(acc_s) * SAT_W'($signed({1'b0, amp_coef}));

   // Registered band output, forced to zero when the band is disabled.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         sig_out <= '0;
      end else if (ena) begin
         sig_out <= sat_ow(gain_s);
      end else begin
         sig_out <= '0;
      end
   end

endmodule

// File: rtl/equalizer_8band.sv
// 8-band graphic equalizer: one shared sample delay line feeding eight
// independent band-pass/gain/saturation channels.
module equalizer_8band
   import eq_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic signed [DW-1:0]  x_in,
   input  logic                  ena_1,
   input  logic                  ena_2,
   input  logic                  ena_3,
   input  logic                  ena_4,
   input  logic                  ena_5,
   input  logic                  ena_6,
   input  logic                  ena_7,
   input  logic                  ena_8,
   input  logic [GW-1:0]         amp_coef_1,
   input  logic [GW-1:0]         amp_coef_2,
   input  logic [GW-1:0]         amp_coef_3,
   input  logic [GW-1:0]         amp_coef_4,
   input  logic [GW-1:0]         amp_coef_5,
   input  logic [GW-1:0]         amp_coef_6,
   input  logic [GW-1:0]         amp_coef_7,
   input  logic [GW-1:0]         amp_coef_8,
   output logic signed [OW-1:0]  sig_out_1,
   output logic signed [OW-1:0]  sig_out_2,
   output logic signed [OW-1:0]  sig_out_3,
   output logic signed [OW-1:0]  sig_out_4,
   output logic signed [OW-1:0]  sig_out_5,
   output logic signed [OW-1:0]  sig_out_6,
   output logic signed [OW-1:0]  sig_out_7,
   output logic signed [OW-1:0]  sig_out_8
);

   logic [NTAPS-1:0][DW-1:0] taps_r;
   logic [NBANDS-1:0]        ena_s;
   logic [GW-1:0]            amp_s  [NBANDS];
   logic signed [OW-1:0]     band_s [NBANDS];

   assign ena_s = {ena_8, ena_7, ena_6, ena_5, ena_4, ena_3, ena_2, ena_1};

   assign amp_s[0] = amp_coef_1;
   assign amp_s[1] = amp_coef_2;
   assign amp_s[2] = amp_coef_3;
   assign amp_s[3] = amp_coef_4;
   assign amp_s[4] = amp_coef_5;
   assign amp_s[5] = amp_coef_6;
   assign amp_s[6] = amp_coef_7;
   assign amp_s[7] = amp_coef_8;

   // Shared delay line, free-running regardless of band enables.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         taps_r <= '0;
      end else begin
         taps_r[0] <= x_in;
         for (int i = 1; i < NTAPS; i++) begin
            taps_r[i] <= taps_r[i-1];
         end
      end
   end

   for (genvar k = 0; k < NBANDS; k++) begin : g_band
      eq_band_fir #(.BAND(k)) u_band (
         .clk      (clk),
         .rst_n    (rst_n),
         .taps     (taps_r),
         .ena      (ena_s[k]),
         .amp_coef (amp_s[k]),
         .sig_out  (band_s[k])
      );
   end

   assign sig_out_1 = band_s[0];
   assign sig_out_2 = band_s[1];
   assign sig_out_3 = band_s[2];
   assign sig_out_4 = band_s[3];
   assign sig_out_5 = band_s[4];
   assign sig_out_6 = band_s[5];
   assign sig_out_7 = band_s[6];
   assign sig_out_8 = band_s[7];

endmodule

// File: tb/tb_equalizer_8band.sv
// Directed self-checking bench for equalizer_8band: reset, impulse, gain,
// enable gating, saturation, mid-stream reset and a cyclic stream.
module tb_equalizer_8band;

   logic              clk = 1'b0;
   logic              rst_n;
   logic signed [15:0] x_in;
   logic              ena [8];
   logic [2:0]        amp [8];
   logic [31:0]       outs [8];

   int tests = 0;
   int fails = 0;

   // Half of each symmetric band table (taps 0..7); taps 8..15 mirror them.
   int half_tbl [8][8] = '{
      '{100, 300, 700, 1200, 1800, 2400, 2900, 3200},
      '{-300, -500, -400, 200, 1100, 2000, 2600, 2800},
      '{200, 400, 0, -900, -1400, -300, 1800, 3300},
      '{-100, 500, 600, -700, -1800, 300, 2900, 1500},
      '{300, -200, -900, 600, 1700, -1600, -1900, 3000},
      '{-200, -600, 900, 500, -2000, 1100, 2200, -2900},
      '{100, 700, -1200, 1300, -800, -600, 2100, -3100},
      '{-300, 600, -900, 1200, -1500, 1800, -2100, 2400}
   };

   longint mt [16];
   logic signed [15:0] stream [8000];

   always #5 clk = ~clk;

   equalizer_8band dut (
      .clk(clk), .rst_n(rst_n), .x_in(x_in),
      .ena_1(ena[0]), .ena_2(ena[1]), .ena_3(ena[2]), .ena_4(ena[3]),
      .ena_5(ena[4]), .ena_6(ena[5]), .ena_7(ena[6]), .ena_8(ena[7]),
      .amp_coef_1(amp[0]), .amp_coef_2(amp[1]), .amp_coef_3(amp[2]), .amp_coef_4(amp[3]),
      .amp_coef_5(amp[4]), .amp_coef_6(amp[5]), .amp_coef_7(amp[6]), .amp_coef_8(amp[7]),
      .sig_out_1(outs[0]), .sig_out_2(outs[1]), .sig_out_3(outs[2]), .sig_out_4(outs[3]),
      .sig_out_5(outs[4]), .sig_out_6(outs[5]), .sig_out_7(outs[6]), .sig_out_8(outs[7])
   );

   function automatic int coef(input int k, input int i);
      return (i < 8) ? half_tbl[k][i] : half_tbl[k][15-i];
   endfunction

   // Reference: FIR over the model taps, gain, saturation, enable gate.
   function automatic logic [31:0] model(input int k, input logic e, input logic [2:0] a);
      longint acc = 0;
      for (int i = 0; i < 16; i++) acc += mt[i] * longint'(coef(k, i));
      acc = acc * longint'(a);
      if (!e) return 32'd0;
      if (acc > 64'sd2147483647) return 32'h7FFFFFFF;
      if (acc < -64'sd2147483648) return 32'h80000000;
      return acc[31:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, predict from pre-edge state, sample #1 after edge.
   task automatic cycle(input logic r, input logic signed [15:0] x, input string phase);
      logic [31:0] exp [8];
      rst_n = r;
      x_in  = x;
      for (int k = 0; k < 8; k++) exp[k] = r ? 32'd0 : model(k, ena[k], amp[k]);
      @(posedge clk);
      #1;
      if (r) begin
         for (int i = 0; i < 16; i++) mt[i] = 0;
      end else begin
         for (int i = 15; i > 0; i--) mt[i] = mt[i-1];
         mt[0] = longint'(x);
      end
      for (int k = 0; k < 8; k++) check($sformatf("%s_band%0d", phase, k+1), outs[k], exp[k]);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mt[i] = 0;
      for (int i = 0; i < 8000; i++) stream[i] = 16'($urandom);
      for (int k = 0; k < 8; k++) begin
         ena[k] = 1'b1;
         amp[k] = 3'd7;
      end
      rst_n = 1'b1;
      x_in  = 16'sh7FFF;

      // Reset dominates a full-scale input with every band enabled at max gain.
      for (int c = 0; c < 3; c++) cycle(1'b1, 16'sh7FFF, "reset");
      for (int k = 0; k < 8; k++) check($sformatf("reset_zero_band%0d", k+1), outs[k], 32'd0);
      for (int c = 0; c < 4; c++) cycle(1'b0, 16'sd0, "post_reset");
      for (int k = 0; k < 8; k++) check($sformatf("idle_zero_band%0d", k+1), outs[k], 32'd0);

      // Impulse, unity gain: output n edges later is 1000 * coef n.
      for (int k = 0; k < 8; k++) amp[k] = 3'd1;
      cycle(1'b0, 16'sd1000, "imp_load");
      for (int n = 0; n <= 16; n++) begin
         cycle(1'b0, 16'sd0, "imp");
         for (int k = 0; k < 8; k++)
            check($sformatf("imp_n%0d_band%0d", n, k+1), outs[k],
                  (n < 16) ? 32'(1000 * coef(k, n)) : 32'd0);
      end

      // Gain: band 3 at x5, band 6 muted by zero gain.
      amp[2] = 3'd5;
      amp[5] = 3'd0;
      cycle(1'b0, 16'sd1000, "gain_load");
      for (int n = 0; n <= 16; n++) begin
         cycle(1'b0, 16'sd0, "gain");
         for (int k = 0; k < 8; k++)
            check($sformatf("gain_n%0d_band%0d", n, k+1), outs[k],
                  (n == 16 || k == 5) ? 32'd0 :
                  (k == 2) ? 32'(5000 * coef(k, n)) : 32'(1000 * coef(k, n)));
      end

      // Enable gating on a random stream with mixed gains.
      for (int k = 0; k < 8; k++) amp[k] = 3'(k + 1);
      for (int c = 0; c < 2000; c++) cycle(1'b0, 16'($urandom), "stream");
      ena[2] = 1'b0;
      ena[6] = 1'b0;
      for (int c = 0; c < 40; c++) begin
         cycle(1'b0, 16'($urandom), "gated");
         check("gated_band3_zero", outs[2], 32'd0);
         check("gated_band7_zero", outs[6], 32'd0);
      end
      ena[2] = 1'b1;
      for (int c = 0; c < 40; c++) cycle(1'b0, 16'($urandom), "reenable");
      ena[6] = 1'b1;

      // Saturation at both rails; bands 1 and 2 overflow the 32-bit range.
      for (int k = 0; k < 8; k++) amp[k] = 3'd7;
      for (int c = 0; c < 20; c++) cycle(1'b0, 16'sh7FFF, "sat_pos");
      check("sat_pos_band1", outs[0], 32'h7FFFFFFF);
      check("sat_pos_band2", outs[1], 32'h7FFFFFFF);
      for (int c = 0; c < 20; c++) cycle(1'b0, -16'sd32768, "sat_neg");
      check("sat_neg_band1", outs[0], 32'h80000000);
      check("sat_neg_band2", outs[1], 32'h80000000);

      // Mid-stream reset discards history.
      cycle(1'b1, 16'sh1234, "mid_reset");
      cycle(1'b0, 16'sd0, "mid_reset_idle");
      for (int k = 0; k < 8; k++) check($sformatf("mid_reset_band%0d", k+1), outs[k], 32'd0);

      // Cyclic stream over two full passes, continuous across the wrap.
      for (int k = 0; k < 8; k++) amp[k] = 3'(7 - k);
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < 8000; i++) cycle(1'b0, stream[i], "wrap");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
